// File: rtl/multiword_add_sequencer_pkg.sv
// Shared types and sizing helpers for the multi-word add sequencer.
// W / IDX_W below describe the default build; the top derives its own from its parameters.
package mwadd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mwadd_state_e;

  localparam int MW_N     = 8;
  localparam int MW_WORDS = 4;
  localparam int W        = MW_N * MW_WORDS;

  // Chunk index width; a single-chunk build still needs a 1-bit register.
  function automatic int idx_width(input int words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

  localparam int IDX_W = idx_width(MW_WORDS);

endpackage

// File: rtl/carry_skip_adder.sv
// N-bit carry-skip adder: ripple inside each BLOCK_SIZE block, and a block whose
// bits all propagate forwards its incoming carry directly to the next block.
module carry_skip_adder #(
  parameter int N          = 8,
  parameter int BLOCK_SIZE = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  localparam int NB = N / BLOCK_SIZE;

  logic c;
  logic cb;
  logic p;

  always_comb begin
    s    = '0;
    c    = cin;
    cb   = 1'b0;
    p    = 1'b1;
    for (int blk = 0; blk < NB; blk++) begin
      cb = c;
      p  = 1'b1;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        s[blk*BLOCK_SIZE+i] = a[blk*BLOCK_SIZE+i] ^ b[blk*BLOCK_SIZE+i] ^ cb;
        cb = (a[blk*BLOCK_SIZE+i] & b[blk*BLOCK_SIZE+i]) |
             (cb & (a[blk*BLOCK_SIZE+i] ^ b[blk*BLOCK_SIZE+i]));
        p  = p & (a[blk*BLOCK_SIZE+i] ^ b[blk*BLOCK_SIZE+i]);
      end
      // skip path: a fully-propagating block passes its carry-in straight through
      c = p ? c : cb;
    end
    cout = c;
  end

endmodule

// File: rtl/multiword_add_sequencer.sv
// Wide adder built from one narrow carry_skip_adder, one N-bit chunk per cycle, LSB first.
// Build option MWADD_SUB_EN adds a sub port turning the operation into a - b.
module multiword_add_sequencer
  import mwadd_pkg::*;
#(
  parameter int N          = 8,
  parameter int BLOCK_SIZE = 4,
  parameter int WORDS      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*WORDS-1:0] a,
  input  logic [N*WORDS-1:0] b,
  input  logic             cin,
`ifdef MWADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*WORDS-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int TW = N * WORDS;
  localparam int IW = idx_width(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  mwadd_state_e state, state_nx;

  logic [IW-1:0] idx;
  logic          carry;
  logic [TW-1:0] a_q;
  logic [TW-1:0] b_q;
  logic [TW-1:0] sum_q;
  logic          cout_q;
  logic [N-1:0]  chunk_a;
  logic [N-1:0]  chunk_b;
  logic [N-1:0]  chunk_s;
  logic          chunk_c;
  logic          accept;
  logic [TW-1:0] b_in;
  logic          c_in;

`ifdef MWADD_SUB_EN
  // two's complement subtract: invert b and force the initial carry to 1
  assign b_in = sub ? ~b : b;
  assign c_in = sub ? 1'b1 : cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif

  assign accept  = in_valid && in_ready;
  assign chunk_a = a_q[int'(idx)*N +: N];
  assign chunk_b = b_q[int'(idx)*N +: N];

  carry_skip_adder #(.N(N), .BLOCK_SIZE(BLOCK_SIZE)) u_csa (
    .a    (chunk_a),
    .b    (chunk_b),
    .cin  (carry),
    .s    (chunk_s),
    .cout (chunk_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        if (idx == LAST) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (accept) begin
      idx   <= '0;
      carry <= c_in;
      a_q   <= a;
      b_q   <= b_in;
    end else if (state == RUN) begin
      sum_q[int'(idx)*N +: N] <= chunk_s;
      carry <= chunk_c;
      if (idx == LAST) begin
        cout_q <= chunk_c;
        idx    <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed bench for multiword_add_sequencer (N=8, BLOCK_SIZE=4, WORDS=4).
// Subtract scenario is compiled in only with MWADD_SUB_EN.
module tb_multiword_add_sequencer;

  localparam int N     = 8;
  localparam int BS    = 4;
  localparam int WORDS = 4;
  localparam int TW    = N * WORDS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] a;
  logic [TW-1:0] b;
  logic          cin;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] sum;
  logic          cout;
  logic          busy;

  int total = 0;
  int passed = 0;

  multiword_add_sequencer #(.N(N), .BLOCK_SIZE(BS), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef MWADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair for a single edge; block is IDLE so it is accepted there.
  task automatic accept_op(input logic [TW-1:0] av, input logic [TW-1:0] bv,
                           input logic c, input logic s);
    a = av; b = bv; cin = c; sub = s; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Counts cycles after the accepting edge until out_valid; bounded.
  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      tick();
      if (!out_valid) cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    total++;
    if ({in_ready, out_valid, busy, cout} !== 4'b1000 || sum !== '0)
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b cout=%b sum=%h, want 1 0 0 0 00000000",
               in_ready, out_valid, busy, cout, sum);
    else passed++;
  endtask

  task automatic test_full_carry();
    int cyc;
    accept_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL carry_run: busy=%b in_ready=%b, want 1 0", busy, in_ready);
    else passed++;
    tick(); tick(); tick();
    cyc = 4;
    if (!out_valid) begin
      wait_valid(cyc);
      cyc = cyc + 3;
    end
    total++;
    if (cyc !== WORDS || out_valid !== 1'b1)
      $display("FAIL carry_latency: cycles=%0d valid=%b, want %0d 1", cyc, out_valid, WORDS);
    else passed++;
    total++;
    if (sum !== 32'h0 || cout !== 1'b1)
      $display("FAIL carry_result: sum=%h cout=%b, want 00000000 1", sum, cout);
    else passed++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int cyc;
    int bad;
    accept_op(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
    wait_valid(cyc);
    total++;
    if (cyc !== WORDS)
      $display("FAIL bp_latency: cycles=%0d, want %0d", cyc, WORDS);
    else passed++;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (sum !== 32'h2345_678A || cout !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0)
        bad++;
      tick();
    end
    total++;
    if (bad != 0)
      $display("FAIL bp_hold: %0d bad cycles (last sum=%h cout=%b valid=%b in_ready=%b), want 0 with 2345678a 0 1 0",
               bad, sum, cout, out_valid, in_ready);
    else passed++;
    total++;
    if (sum !== 32'h2345_678A || cout !== 1'b0)
      $display("FAIL bp_result: sum=%h cout=%b, want 2345678a 0", sum, cout);
    else passed++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b, want 0 1 0", out_valid, in_ready, busy);
    else passed++;
  endtask

  task automatic test_ignore_inputs();
    int cyc;
    a = 32'h0000_00FF; b = 32'h0000_0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    cyc = 1;
    // keep offering a different operand pair while the block is busy
    while (!out_valid && cyc < 40) begin
      a = 32'hAAAA_5555 ^ cyc; b = 32'h0F0F_F0F0; cin = 1'b1;
      tick();
      if (!out_valid) cyc++;
    end
    total++;
    if (cyc !== WORDS)
      $display("FAIL ignore_latency: cycles=%0d, want %0d", cyc, WORDS);
    else passed++;
    total++;
    if (sum !== 32'h0000_0100 || cout !== 1'b0)
      $display("FAIL ignore_result: sum=%h cout=%b, want 00000100 0", sum, cout);
    else passed++;
    tick();
    total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL ignore_no_accept_in_done: out_valid=%b in_ready=%b, want 1 0", out_valid, in_ready);
    else passed++;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_abort_reset();
    int cyc;
    accept_op(32'hFFFF_0000, 32'h0001_FFFF, 1'b0, 1'b0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, busy, cout} !== 4'b1000 || sum !== '0)
      $display("FAIL abort_reset: in_ready=%b out_valid=%b busy=%b cout=%b sum=%h, want 1 0 0 0 00000000",
               in_ready, out_valid, busy, cout, sum);
    else passed++;
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL abort_no_result: out_valid=%b busy=%b, want 0 0", out_valid, busy);
    else passed++;
    accept_op(32'd3, 32'd4, 1'b0, 1'b0);
    wait_valid(cyc);
    total++;
    if (out_valid !== 1'b1 || sum !== 32'd7 || cout !== 1'b0)
      $display("FAIL abort_next_op: valid=%b sum=%h cout=%b, want 1 00000007 0", out_valid, sum, cout);
    else passed++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

`ifdef MWADD_SUB_EN
  task automatic test_subtract();
    int cyc;
    accept_op(32'd5, 32'd7, 1'b0, 1'b1);
    wait_valid(cyc);
    total++;
    if (out_valid !== 1'b1 || sum !== 32'hFFFF_FFFE || cout !== 1'b0)
      $display("FAIL sub_borrow: valid=%b sum=%h cout=%b, want 1 fffffffe 0", out_valid, sum, cout);
    else passed++;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    accept_op(32'd7, 32'd5, 1'b0, 1'b1);
    wait_valid(cyc);
    total++;
    if (out_valid !== 1'b1 || sum !== 32'd2 || cout !== 1'b1)
      $display("FAIL sub_no_borrow: valid=%b sum=%h cout=%b, want 1 00000002 1", out_valid, sum, cout);
    else passed++;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_full_carry();
    test_backpressure();
    test_ignore_inputs();
    test_abort_reset();
`ifdef MWADD_SUB_EN
    test_subtract();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
